// File: rtl/im_program_loader.sv
// im_program_loader
//   Byte-stream front end for the 32 x 26-bit instruction memory. Bytes are
//   assembled little-endian into 26-bit words, and each word is written in
//   the one cycle where the memory's free-running address counter points at
//   the word's target address. The memory counter is reset once per load
//   (SYNC). From then on, an internal shadow counter tracks it in lock-step.
//
// Ports
//   clk, pl_rst          clock / async active-high reset
//   pl_start             begin a load (only looked at in IDLE)
//   pl_byte[7:0]         program byte, with pl_byte_valid / pl_byte_ready handshake
//   im_rst               memory counter reset, one cycle per load
//   im_ld_en             memory load enable
//   im_instLoad[25:0]    memory load data
//   pl_busy              high while synchronising or loading
//   pl_done              one-cycle pulse after the last word is written
//   pl_count[5:0]        words written in the current load
module im_program_loader #(
  parameter int NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        pl_rst,
  input  logic        pl_start,
  input  logic [7:0]  pl_byte,
  input  logic        pl_byte_valid,
  output logic        pl_byte_ready,
  output logic        im_rst,
  output logic        im_ld_en,
  output logic [25:0] im_instLoad,
  output logic        pl_busy,
  output logic        pl_done,
  output logic [5:0]  pl_count
);

  typedef enum logic [1:0] {IDLE, SYNC, LOAD, DONE} state_t;

  localparam logic [5:0] LAST = 6'(NUM_WORDS);

  state_t      state;
  logic [4:0]  shadow;     // mirror of the memory's address counter
  logic [5:0]  wr_idx;     // address of the next word to write
  logic [1:0]  byte_cnt;
  logic        word_full;  // hold contains a complete, unwritten word
  logic [23:0] asm_lo;     // bytes 0..2 of the word being assembled
  logic [25:0] hold;
  logic        xfer;

  // All handshake and memory-control outputs decode registered state only.
  assign pl_byte_ready = (state == LOAD) && !word_full;
  assign xfer          = pl_byte_ready && pl_byte_valid;
  assign im_ld_en      = (state == LOAD) && word_full && (shadow == wr_idx[4:0]);
  assign im_rst        = (state == SYNC);
  assign pl_busy       = (state == SYNC) || (state == LOAD);
  assign pl_done       = (state == DONE);
  assign im_instLoad   = hold;
  // Words written so far; wr_idx stops at NUM_WORDS, so it saturates there.
  assign pl_count      = wr_idx;

  always_ff @(posedge clk or posedge pl_rst) begin
    if (pl_rst) begin
      state     <= IDLE;
      shadow    <= '0;
      wr_idx    <= '0;
      byte_cnt  <= '0;
      word_full <= 1'b0;
      asm_lo    <= '0;
      hold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pl_start) begin
            state     <= SYNC;
            wr_idx    <= '0;
            byte_cnt  <= '0;
            word_full <= 1'b0;
          end
        end
        SYNC: begin
          // im_rst is high this cycle, so the memory counter is also 0 next cycle.
          shadow <= '0;
          state  <= LOAD;
        end
        LOAD: begin
          shadow <= shadow + 5'd1;
          // xfer needs !word_full and a write needs word_full, so the two
          // branches never fire in the same cycle.
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_lo[7:0]   <= pl_byte;
              2'd1: asm_lo[15:8]  <= pl_byte;
              2'd2: asm_lo[23:16] <= pl_byte;
              default: begin
                // hold is updated only when a word completes, so the memory
                // data pins stay stable while the next word is assembled.
                hold      <= {pl_byte[1:0], asm_lo};
                word_full <= 1'b1;
              end
            endcase
          end
          if (im_ld_en) begin
            word_full <= 1'b0;
            wr_idx    <= wr_idx + 6'd1;
            if (wr_idx + 6'd1 == LAST)
              state <= DONE;
          end
        end
        DONE: begin
          hold  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
